// File: rtl/comparator_pkg.sv
// Shared types and helpers for the registered magnitude comparator.
// A relation is carried through the reduction tree as a 2-bit code;
// the all-ones code is never produced by any slice or merge node.
package comparator_pkg;

    typedef enum logic [1:0] {
        REL_EQ = 2'b00,
        REL_LT = 2'b01,
        REL_GT = 2'b10
    } cmp_rel_t;

    // Combine the relation of a more-significant chunk (hi) with that of a
    // less-significant chunk (lo): the upper chunk decides unless it is equal.
    function automatic cmp_rel_t rel_merge(input cmp_rel_t hi, input cmp_rel_t lo);
        return (hi != REL_EQ) ? hi : lo;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one SLICE_W-bit chunk of the operands.
// Produces the relation of a_slice versus b_slice as a cmp_rel_t code.
module cmp_slice
    import comparator_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a_slice,
    input  logic [SLICE_W-1:0] b_slice,
    output cmp_rel_t           rel
);

    // Classify the chunk pair; equal is the default so the merge tree passes it through.
    always_comb begin
        rel = REL_EQ;
        if (a_slice > b_slice) begin
            rel = REL_GT;
        end else if (a_slice < b_slice) begin
            rel = REL_LT;
        end
    end

endmodule

// File: rtl/comparator_8bit.sv
// Registered unsigned magnitude comparator.
// The operands are split into SLICE_W-bit chunks (MSB chunk first), each chunk
// is compared by a cmp_slice, and the chunk relations are reduced by a balanced
// binary tree of rel_merge nodes. The root relation is decoded to one-hot flags
// and registered, so the outputs change only on clk (or clear on rst).
module comparator_8bit
    import comparator_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             equal,
    output logic             lower,
    output logic             greater
);

    // Tree geometry: the leaf level is padded up to a power of two. Padding
    // leaves sit at the least-significant end and carry REL_EQ, which is the
    // identity of rel_merge on its lo argument, so they never alter the result.
    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int TREE_DEPTH = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 0;
    localparam int NUM_LEAVES = 1 << TREE_DEPTH;

    cmp_rel_t root_rel;

    logic equal_d;
    logic lower_d;
    logic greater_d;
    logic equal_q;
    logic lower_q;
    logic greater_q;

    genvar gl;
    genvar gi;

    // Level 0 holds the slice results (index 0 = most significant chunk);
    // each following level halves the node count by merging adjacent pairs,
    // the even (left) member always being the more significant one.
    generate
        for (gl = 0; gl <= TREE_DEPTH; gl++) begin : g_lvl
            localparam int LVL_NODES = NUM_LEAVES >> gl;

            cmp_rel_t node [LVL_NODES];

            for (gi = 0; gi < LVL_NODES; gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    if (gi < NUM_SLICES) begin : g_slice
                        cmp_slice #(
                            .SLICE_W (SLICE_W)
                        ) u_slice (
                            .a_slice (a[WIDTH-1-gi*SLICE_W -: SLICE_W]),
                            .b_slice (b[WIDTH-1-gi*SLICE_W -: SLICE_W]),
                            .rel     (node[gi])
                        );
                    end else begin : g_pad
                        assign node[gi] = REL_EQ;
                    end
                end else begin : g_merge
                    assign node[gi] = rel_merge(g_lvl[gl-1].node[2*gi],
                                                g_lvl[gl-1].node[2*gi+1]);
                end
            end
        end
    endgenerate

    assign root_rel = g_lvl[TREE_DEPTH].node[0];

    // Decode the root relation into the three one-hot flag values.
    always_comb begin
        equal_d   = 1'b0;
        lower_d   = 1'b0;
        greater_d = 1'b0;
        case (root_rel)
            REL_EQ:  equal_d   = 1'b1;
            REL_LT:  lower_d   = 1'b1;
            REL_GT:  greater_d = 1'b1;
            default: ;
        endcase
    end

    // Flag registers; rst clears them immediately and independently of a/b,
    // which also drops any compare sampled before the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            equal_q   <= 1'b0;
            lower_q   <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            equal_q   <= equal_d;
            lower_q   <= lower_d;
            greater_q <= greater_d;
        end
    end

    assign equal   = equal_q;
    assign lower   = lower_q;
    assign greater = greater_q;

endmodule

// File: tb/tb_comparator_8bit.sv
// Self-checking bench for comparator_8bit (WIDTH=8, SLICE_W=4).
// Expected flags are pushed to a scoreboard when a pair is driven and popped
// when the flags are sampled 20 time units (two rising edges) later.
module tb_comparator_8bit;

    localparam int W = 8;

    // Flag vector order: {equal, lower, greater}
    localparam logic [2:0] F_EQ   = 3'b100;
    localparam logic [2:0] F_LT   = 3'b010;
    localparam logic [2:0] F_GT   = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         equal;
    logic         lower;
    logic         greater;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q [$];
    string      tag_q [$];

    comparator_8bit #(
        .WIDTH   (W),
        .SLICE_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .equal   (equal),
        .lower   (lower),
        .greater (greater)
    );

    always #5 clk = ~clk;

    // Plain unsigned reference compare.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == y)     return F_EQ;
        else if (x < y) return F_LT;
        else            return F_GT;
    endfunction

    task automatic check_flags(input string tag, input logic [2:0] expv);
        logic [2:0] obs;
        obs = {equal, lower, greater};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: flags{eq,lw,gr}=%b expected %b (a=%0d b=%0d rst=%b)",
                   tag, obs, expv, a, b, rst);
        end
    endtask

    // Drive a pair at a falling edge, queue its expectation, sample after two edges.
    task automatic run_pair(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [2:0] expv, input bit verbose);
        logic [2:0] e;
        string      t;
        a = x;
        b = y;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_flags(t, e);
        if (verbose)
            $display("txn %s a=%0d b=%0d flags=%b expected=%b", t, x, y,
                     {equal, lower, greater}, e);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           oh_bad;

        // Reset with unknown operands: flags must be deterministic zero.
        rst = 1'b1;
        a   = 'x;
        b   = 'x;
        @(negedge clk);
        check_flags("reset_x_inputs", F_NONE);
        $display("txn reset_x_inputs flags=%b", {equal, lower, greater});
        @(negedge clk);
        check_flags("reset_held", F_NONE);

        // Release: the first edge after rst falls shows that edge's operands.
        rst = 1'b0;
        run_pair("release_first", 8'd3, 8'd9, F_LT, 1'b1);

        // 1. Exhaustive low range
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_pair($sformatf("low_%0d_%0d", i, j), W'(i), W'(j),
                         ref_flags(W'(i), W'(j)), 1'b0);
            end
        end
        $display("txn low_range 256 pairs done");

        // 2. Extremes
        run_pair("max_vs_zero", 8'd255, 8'd0,   F_GT, 1'b1);
        run_pair("zero_vs_max", 8'd0,   8'd255, F_LT, 1'b1);
        run_pair("max_vs_max",  8'd255, 8'd255, F_EQ, 1'b1);
        run_pair("128_vs_127",  8'd128, 8'd127, F_GT, 1'b1);

        // 3. Slice boundary
        run_pair("h10_vs_h0f",  8'h10, 8'h0F, F_GT, 1'b1);
        run_pair("h0f_vs_h10",  8'h0F, 8'h10, F_LT, 1'b1);
        run_pair("ha5_vs_ha6",  8'hA5, 8'hA6, F_LT, 1'b1);
        run_pair("h5a_vs_h4b",  8'h5A, 8'h4B, F_GT, 1'b1);

        // 4. Latency: change operands just after an edge; old relation holds.
        run_pair("lat_setup_gt", 8'd200, 8'd100, F_GT, 1'b1);
        @(posedge clk);
        #1;
        a = 8'd10;
        b = 8'd20;
        #3;
        check_flags("lat_hold_old", F_GT);
        $display("txn lat_hold_old flags=%b", {equal, lower, greater});
        @(posedge clk);
        #1;
        check_flags("lat_update_new", F_LT);
        $display("txn lat_update_new flags=%b", {equal, lower, greater});

        // 5. Asynchronous reset pulse between edges while greater is set.
        run_pair("arst_setup_gt", 8'd77, 8'd33, F_GT, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_flags("arst_clear_async", F_NONE);
        #1;
        rst = 1'b0;
        #1;
        check_flags("arst_hold_after_release", F_NONE);
        $display("txn arst_pulse flags=%b", {equal, lower, greater});
        @(posedge clk);
        #1;
        check_flags("arst_restore", F_GT);
        $display("txn arst_restore flags=%b", {equal, lower, greater});

        // 6. Random pairs: one-hot property plus reference compare.
        oh_bad = 0;
        for (int n = 0; n < 10000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if ((n % 7) == 0) rb = ra;
            run_pair($sformatf("rand_%0d", n), ra, rb, ref_flags(ra, rb), 1'b0);
            checks++;
            assert ($onehot({equal, lower, greater})) else begin
                failures++;
                oh_bad++;
                $error("FAIL onehot_%0d: flags{eq,lw,gr}=%b expected exactly one bit set",
                       n, {equal, lower, greater});
            end
        end
        $display("txn random 10000 pairs done onehot_violations=%0d", oh_bad);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
